// File: rtl/layer_score_scan.sv
// Scores one sample of the learn layer: argmax of out and expected_out, plus summed |out-expected_out|.
// Optional SCORE_STATS_EN builds saturating counters of transferred and correct samples.
module layer_score_scan #(
    parameter int N      = 49,
    parameter int W      = 8,
    parameter int SETTLE = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N-1:0][W-1:0]       out,
    input  logic [N-1:0][W-1:0]       expected_out,
    output logic                      busy,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [$clog2(N)-1:0]      best_idx,
    output logic [W-1:0]              best_val,
    output logic [$clog2(N)-1:0]      exp_idx,
    output logic                      correct,
    output logic [W+$clog2(N)-1:0]    err_sum,
    output logic [15:0]               stat_total,
    output logic [15:0]               stat_correct
);

    localparam int IW = $clog2(N);
    localparam int EW = W + IW;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_SCAN,
        S_HOLD
    } state_t;

    state_t state;
    state_t next_state;

    logic [SW-1:0] settle_cnt;
    logic [IW-1:0] scan_idx;
    logic          scan_last;
    logic          xfer;

    logic [W-1:0]  snap_out [N];
    logic [W-1:0]  snap_exp [N];

    logic [IW-1:0] acc_best_idx;
    logic [W-1:0]  acc_best_val;
    logic [IW-1:0] acc_exp_idx;
    logic [W-1:0]  acc_exp_val;
    logic [EW-1:0] acc_err;

    logic [W-1:0]  cur_out;
    logic [W-1:0]  cur_exp;
    logic [W-1:0]  cur_diff;
    logic [IW-1:0] nxt_best_idx;
    logic [W-1:0]  nxt_best_val;
    logic [IW-1:0] nxt_exp_idx;
    logic [W-1:0]  nxt_exp_val;
    logic [EW-1:0] nxt_err;

    // Result handshake: res_valid is high for every HOLD cycle and the outputs
    // are frozen; a transfer happens on a clock edge where res_valid && res_ready.
    assign busy      = (state != S_IDLE);
    assign res_valid = (state == S_HOLD);
    assign xfer      = res_valid && res_ready;
    assign scan_last = (state == S_SCAN) && (scan_idx == IW'(N - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == SW'(SETTLE - 1)) begin
                    next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: next_state = S_SCAN;
            S_SCAN: begin
                if (scan_last) begin
                    next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // One scan step: strict greater-than keeps the lowest index on ties.
    always_comb begin
        cur_out      = snap_out[scan_idx];
        cur_exp      = snap_exp[scan_idx];
        cur_diff     = (cur_out > cur_exp) ? (cur_out - cur_exp) : (cur_exp - cur_out);
        nxt_best_idx = acc_best_idx;
        nxt_best_val = acc_best_val;
        nxt_exp_idx  = acc_exp_idx;
        nxt_exp_val  = acc_exp_val;
        nxt_err      = acc_err + {{IW{1'b0}}, cur_diff};
        if (cur_out > acc_best_val) begin
            nxt_best_idx = scan_idx;
            nxt_best_val = cur_out;
        end
        if (cur_exp > acc_exp_val) begin
            nxt_exp_idx = scan_idx;
            nxt_exp_val = cur_exp;
        end
    end

    always_ff @(posedge clock) begin
        if (state == S_CAPTURE) begin
            for (int i = 0; i < N; i++) begin
                snap_out[i] <= out[i];
                snap_exp[i] <= expected_out[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            settle_cnt   <= '0;
            scan_idx     <= '0;
            acc_best_idx <= '0;
            acc_best_val <= '0;
            acc_exp_idx  <= '0;
            acc_exp_val  <= '0;
            acc_err      <= '0;
            best_idx     <= '0;
            best_val     <= '0;
            exp_idx      <= '0;
            correct      <= 1'b0;
            err_sum      <= '0;
        end else begin
            case (state)
                S_IDLE: settle_cnt <= '0;
                S_SETTLE: settle_cnt <= settle_cnt + 1'b1;
                S_CAPTURE: begin
                    scan_idx     <= '0;
                    acc_best_idx <= '0;
                    acc_best_val <= '0;
                    acc_exp_idx  <= '0;
                    acc_exp_val  <= '0;
                    acc_err      <= '0;
                end
                S_SCAN: begin
                    scan_idx     <= scan_idx + 1'b1;
                    acc_best_idx <= nxt_best_idx;
                    acc_best_val <= nxt_best_val;
                    acc_exp_idx  <= nxt_exp_idx;
                    acc_exp_val  <= nxt_exp_val;
                    acc_err      <= nxt_err;
                    // Results only move here, so they stay frozen through HOLD.
                    if (scan_last) begin
                        best_idx <= nxt_best_idx;
                        best_val <= nxt_best_val;
                        exp_idx  <= nxt_exp_idx;
                        correct  <= (nxt_best_idx == nxt_exp_idx);
                        err_sum  <= nxt_err;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SCORE_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_total   <= '0;
            stat_correct <= '0;
        end else if (xfer) begin
            if (stat_total != 16'hFFFF) begin
                stat_total <= stat_total + 16'd1;
            end
            if (correct && (stat_correct != 16'hFFFF)) begin
                stat_correct <= stat_correct + 16'd1;
            end
        end
    end
`else
    assign stat_total   = '0;
    assign stat_correct = '0;
`endif

endmodule

// File: tb/tb_layer_score_scan.sv
// Bench for layer_score_scan: table vectors, random samples against a reference model,
// and hand sequences for stalls, ignored starts, mid-scan reset and the SETTLE=0 build.
module tb_layer_score_scan;

    localparam int N  = 49;
    localparam int W  = 8;
    localparam int IW = $clog2(N);
    localparam int EW = W + IW;

    logic                clock = 1'b0;
    logic                reset;
    logic                start;
    logic                start0;
    logic                res_ready;
    logic                ready0;
    logic [N-1:0][W-1:0] out_v;
    logic [N-1:0][W-1:0] exp_v;

    logic          busy, res_valid, correct;
    logic [IW-1:0] best_idx, exp_idx;
    logic [W-1:0]  best_val;
    logic [EW-1:0] err_sum;
    logic [15:0]   stat_total, stat_correct;

    logic          busy_z, res_valid_z, correct_z;
    logic [IW-1:0] best_idx_z, exp_idx_z;
    logic [W-1:0]  best_val_z;
    logic [EW-1:0] err_sum_z;
    logic [15:0]   stat_total_z, stat_correct_z;

    layer_score_scan #(.N(N), .W(W), .SETTLE(2)) dut (
        .clock(clock), .reset(reset), .start(start),
        .out(out_v), .expected_out(exp_v),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .best_idx(best_idx), .best_val(best_val), .exp_idx(exp_idx),
        .correct(correct), .err_sum(err_sum),
        .stat_total(stat_total), .stat_correct(stat_correct)
    );

    layer_score_scan #(.N(N), .W(W), .SETTLE(0)) dut0 (
        .clock(clock), .reset(reset), .start(start0),
        .out(out_v), .expected_out(exp_v),
        .busy(busy_z), .res_valid(res_valid_z), .res_ready(ready0),
        .best_idx(best_idx_z), .best_val(best_val_z), .exp_idx(exp_idx_z),
        .correct(correct_z), .err_sum(err_sum_z),
        .stat_total(stat_total_z), .stat_correct(stat_correct_z)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit ramp;
        int o_base, o_p1, o_p2, o_pv;
        int e_base, e_p, e_pv;
        int stall;
        int x_bi, x_bv, x_ei, x_c, x_err;
    } vec_t;

    vec_t vecs [5];

    int n_checks = 0;
    int n_errors = 0;
    int exp_total = 0;
    int exp_correct = 0;
    int m_bi, m_bv, m_ei, m_c, m_es;
    int maxv, lat, extra;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: argmax with first-occurrence wins, and sum of absolute differences.
    function automatic void model(input logic [N-1:0][W-1:0] o, input logic [N-1:0][W-1:0] e,
                                  output int bi, output int bv, output int ei,
                                  output int c, output int es);
        int ev;
        bi = 0; bv = int'(o[0]); ei = 0; ev = int'(e[0]); es = 0;
        for (int i = 0; i < N; i++) begin
            if (int'(o[i]) > bv) begin bi = i; bv = int'(o[i]); end
            if (int'(e[i]) > ev) begin ei = i; ev = int'(e[i]); end
            es += (int'(o[i]) > int'(e[i])) ? int'(o[i]) - int'(e[i]) : int'(e[i]) - int'(o[i]);
        end
        c = (bi == ei) ? 1 : 0;
    endfunction

    task automatic fill(input vec_t v);
        for (int i = 0; i < N; i++) begin
            out_v[i] = v.ramp ? W'(i) : W'(v.o_base);
            if (i == v.o_p1 || i == v.o_p2) out_v[i] = W'(v.o_pv);
            exp_v[i] = (i == v.e_p) ? W'(v.e_pv) : W'(v.e_base);
        end
    endtask

    task automatic randomize_inputs(input int mv);
        for (int i = 0; i < N; i++) begin
            out_v[i] = W'($urandom_range(0, mv));
            exp_v[i] = W'($urandom_range(0, mv));
        end
    endtask

    task automatic check_results(input string tag, input int bi, input int bv, input int ei,
                                 input int c, input int es);
        check({tag, ".best_idx"}, best_idx, bi);
        check({tag, ".best_val"}, best_val, bv);
        check({tag, ".exp_idx"}, exp_idx, ei);
        check({tag, ".correct"}, correct, c);
        check({tag, ".err_sum"}, err_sum, es);
    endtask

    // Start one sample on dut, wait for the result, stall, then hand it off.
    task automatic run_sample(input string tag, input int stall, input bit scramble,
                              input int bi, input int bv, input int ei, input int c, input int es);
        int l;
        res_ready = (stall == 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        l = 1;
        while (!res_valid && l < 200) begin
            tick();
            l++;
            if (scramble && l == 10) randomize_inputs(255);
        end
        check({tag, ".latency"}, l, 53);
        check_results(tag, bi, bv, ei, c, es);
        for (int k = 0; k < stall; k++) begin
            tick();
            check({tag, ".stall_valid"}, res_valid, 1);
            check({tag, ".stall_err"}, err_sum, es);
            check({tag, ".stall_idx"}, best_idx, bi);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_total++;
        if (c != 0) exp_correct++;
        check({tag, ".busy_after"}, busy, 0);
        check({tag, ".valid_after"}, res_valid, 0);
    endtask

    task automatic check_stats(input string tag);
`ifdef SCORE_STATS_EN
        check({tag, ".stat_total"}, stat_total, exp_total);
        check({tag, ".stat_correct"}, stat_correct, exp_correct);
`else
        check({tag, ".stat_total"}, stat_total, 0);
        check({tag, ".stat_correct"}, stat_correct, 0);
`endif
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".res_valid"}, res_valid, 0);
        check_results(tag, 0, 0, 0, 0, 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 0, -1, -1, 0, 0, -1, 0, 0, 48, 48, 0, 0, 1176};
        vecs[1] = '{1'b0, 10, 5, 9, 200, 0, 5, 255, 10, 5, 200, 5, 1, 725};
        vecs[2] = '{1'b0, 0, -1, -1, 0, 0, -1, 0, 2, 0, 0, 0, 1, 0};
        vecs[3] = '{1'b0, 0, 48, -1, 1, 255, -1, 0, 1, 48, 1, 0, 0, 12494};
        vecs[4] = '{1'b0, 255, -1, -1, 0, 255, -1, 0, 0, 0, 255, 0, 1, 0};

        reset = 1'b1; start = 1'b0; start0 = 1'b0; res_ready = 1'b0; ready0 = 1'b0;
        out_v = '0; exp_v = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_idle_zero("reset");
        check_stats("reset");

        for (int v = 0; v < 5; v++) begin
            fill(vecs[v]);
            run_sample($sformatf("vec%0d", v), vecs[v].stall, 1'b0,
                       vecs[v].x_bi, vecs[v].x_bv, vecs[v].x_ei, vecs[v].x_c, vecs[v].x_err);
        end

        for (int r = 0; r < 8; r++) begin
            maxv = (r % 2 == 1) ? 255 : 3;
            randomize_inputs(maxv);
            model(out_v, exp_v, m_bi, m_bv, m_ei, m_c, m_es);
            run_sample($sformatf("rand%0d", r), $urandom_range(0, 3), (r >= 4),
                       m_bi, m_bv, m_ei, m_c, m_es);
        end
        check_stats("after_table");

        // Extra starts mid-scan and on the handshake cycle must not produce a second result.
        fill(vecs[1]);
        res_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (!res_valid && lat < 200) begin
            tick();
            lat++;
            start = (lat == 20);
        end
        start = 1'b0;
        check("ignored.latency", lat, 53);
        check("ignored.err_sum", err_sum, 725);
        res_ready = 1'b1;
        start = 1'b1;
        tick();
        res_ready = 1'b0;
        start = 1'b0;
        exp_total++;
        exp_correct++;
        check("ignored.busy_drop", busy, 0);
        extra = 0;
        repeat (80) begin
            tick();
            if (busy || res_valid) extra++;
        end
        check("ignored.no_second_result", extra, 0);
        check_stats("ignored");

        // SETTLE=0 instance, all-max vectors.
        fill(vecs[4]);
        ready0 = 1'b0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        lat = 1;
        while (!res_valid_z && lat < 200) begin
            tick();
            lat++;
        end
        check("settle0.latency", lat, 51);
        check("settle0.best_idx", best_idx_z, 0);
        check("settle0.exp_idx", exp_idx_z, 0);
        check("settle0.correct", correct_z, 1);
        check("settle0.err_sum", err_sum_z, 0);
        ready0 = 1'b1;
        tick();
        ready0 = 1'b0;
        check("settle0.busy_after", busy_z, 0);

        // Reset during SCAN discards the partial result.
        fill(vecs[0]);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (29) tick();
        check("midreset.busy_before", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_total = 0;
        exp_correct = 0;
        check_idle_zero("midreset");
        check_stats("midreset");
        check("midreset.dut0_busy", busy_z, 0);
        run_sample("fresh", 0, 1'b0, 48, 48, 0, 0, 1176);
        check_stats("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
